vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Parametrised VGA timing and test-pattern generator. Drives the monitor
//  sync outputs and an RGB pixel bus. Selectable patterns: solid colour,
//  8 colour bars, checkerboard and single highlighted band. Replaces the
//  fixed 640x480 1-bit-per-channel display path. Runs on the 50 MHz system
//  clock, qualified by a pixel-clock enable.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  COLOR_W   1    bits per colour channel; rgb = {R,G,B}, each COLOR_W bits
//  CELL_LOG2 5    checkerboard cell size is 2**CELL_LOG2 pixels
// PORTS
//  clk         in   1          system clock (50 MHz)
//  rst_n       in   1          asynchronous reset, active low
//  pix_en      in   1          pixel tick; all state advances only when high
//  mode        in   2          0 solid, 1 bars, 2 checker, 3 band
//  fg_rgb      in   3*COLOR_W  foreground colour
//  sel_pos     in   4          [2:0] band index; [3] inverts band mode
//  hsync       out  1          horizontal sync, active low
//  vsync       out  1          vertical sync, active low
//  de          out  1          display enable (visible area)
//  x           out  10         current column (valid when de)
//  y           out  10         current row (valid when de)
//  rgb         out  3*COLOR_W  pixel colour; zero when de low
//  frame_start out  1          one-clk pulse at first pixel of a frame
// BEHAVIOUR
//  - H_TOTAL = sum of H_* params; V_TOTAL = sum of V_* params.
//  - Counters: h_cnt 0..H_TOTAL-1 increments on pix_en and wraps to 0.
//    v_cnt increments on the h_cnt wrap and wraps to 0 after V_TOTAL-1.
//  - Reset values: h_cnt=v_cnt=0, hsync=vsync=1, de=0, x=y=0, rgb=0,
//    frame_start=0, shadow regs = mode 0, fg 0, sel 0.
//  - Outputs are registered on pix_en. 1 tick latency: they reflect the
//    counter state before that tick. All outputs mutually aligned.
//  - hsync=0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
//    vsync=0 iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
//    de=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. x=h_cnt, y=v_cnt.
//  - Shadow latch: mode, fg_rgb and sel_pos are captured only when counters
//    are (0,0) and pix_en=1. Mid-frame input changes take effect at the
//    next frame. The pattern for pixel (0,0) already uses the new values.
//  - frame_start=1 for exactly one clk, on the cycle after that latch.
//  - Bar index b (0..7): BAR_W = H_ACTIVE/8 (integer). A bar counter
//    advances every BAR_W pixels and saturates at 7, so any remainder
//    pixels are absorbed into bar 7. No divider is used.
//  - Patterns (when de=1):
//    mode 0: rgb = fg.
//    mode 1: R = {COLOR_W{b[2]}}, G = {COLOR_W{b[1]}}, B = {COLOR_W{b[0]}}.
//    mode 2: rgb = fg if x[CELL_LOG2]^y[CELL_LOG2], else 0.
//    mode 3: hit = (b==sel[2:0]) ^ sel[3]; rgb = hit ? fg : 0.
//  - pix_en low: all registers hold and frame_start is 0.
//  - rst_n low mid-frame: outputs go to reset values immediately.
//    Counting restarts at (0,0) on the first pix_en after release.
// TESTING
//  1 Reset, pix_en=1 every 2nd clk, defaults -> hsync low for 96 ticks in
//    each 800-tick line; vsync low for 2 lines in each 525; de high for
//    640x480 ticks per frame.
//  2 mode=1, COLOR_W=1 -> rgb=000 at x=0, 001 at x=80, 111 at x=639;
//    rgb=000 at x=640 (blanking).
//  3 mode=2, fg=111 -> (0,0)=000, (32,0)=111, (32,32)=000.
//  4 mode=3, sel=4'b0010, fg=100 -> rgb=100 only for x in 160..239;
//    sel=4'b1010 -> inverse.
//  5 Switch mode 0->1 at y=100 -> frame unchanged to its end; bars
//    begin at (0,0) of the next frame, with one frame_start pulse.
//  6 Assert rst_n low at h=300,v=200 -> hsync=vsync=1, de=0, rgb=0 at
//    once. After release, first de rises with x=0,y=0. Also hold pix_en
//    low 20 clks -> all outputs frozen.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: raster counters, sync/DE generation,
// and solid/bars/checker/band patterns, advancing only on pix_en ticks.
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_W   = 1,
  parameter int CELL_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   fg_rgb,
  input  logic [3:0]             sel_pos,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [9:0]             x,
  output logic [9:0]             y,
  output logic [3*COLOR_W-1:0]   rgb,
  output logic                   frame_start
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

  logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]       bar_pix_q, bar_pix_d;
  logic [2:0]       bar_q, bar_d;
  logic [1:0]       mode_q, mode_d;
  logic [RGB_W-1:0] fg_q, fg_d;
  logic [3:0]       sel_q, sel_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q, fs_d;

  logic             frame_top, vis;
  logic [1:0]       mode_eff;
  logic [RGB_W-1:0] fg_eff, pattern;
  logic [3:0]       sel_eff;

  // At (0,0) the live inputs are used so the first pixel already shows the new settings.
  always_comb begin
    frame_top = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    mode_eff  = frame_top ? mode    : mode_q;
    fg_eff    = frame_top ? fg_rgb  : fg_q;
    sel_eff   = frame_top ? sel_pos : sel_q;
    vis       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    pattern   = '0;
    case (mode_eff)
      2'd0: pattern = fg_eff;
      2'd1: pattern = {{COLOR_W{bar_q[2]}}, {COLOR_W{bar_q[1]}}, {COLOR_W{bar_q[0]}}};
      2'd2: pattern = (h_cnt_q[CELL_LOG2] ^ v_cnt_q[CELL_LOG2]) ? fg_eff : '0;
      default: pattern = ((bar_q == sel_eff[2:0]) ^ sel_eff[3]) ? fg_eff : '0;
    endcase
  end

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_pix_d = bar_pix_q;
    bar_d     = bar_q;
    mode_d    = mode_q;
    fg_d      = fg_q;
    sel_d     = sel_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    de_d      = de_q;
    x_d       = x_q;
    y_d       = y_q;
    rgb_d     = rgb_q;
    fs_d      = pix_en && frame_top;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d   = 10'd0;
        v_cnt_d   = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        bar_pix_d = 10'd0;
        bar_d     = 3'd0;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        // Bar index saturates at 7 so leftover pixels widen the last bar.
        if (bar_pix_q == BAR_LAST) begin
          bar_pix_d = 10'd0;
          bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end else begin
          bar_pix_d = bar_pix_q + 10'd1;
        end
      end
      if (frame_top) begin
        mode_d = mode;
        fg_d   = fg_rgb;
        sel_d  = sel_pos;
      end
      hsync_d = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vsync_d = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      de_d    = vis;
      x_d     = h_cnt_q;
      y_d     = v_cnt_q;
      rgb_d   = vis ? pattern : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_pix_q <= '0;
      bar_q     <= '0;
      mode_q    <= '0;
      fg_q      <= '0;
      sel_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_pix_q <= bar_pix_d;
      bar_q     <= bar_d;
      mode_q    <= mode_d;
      fg_q      <= fg_d;
      sel_q     <= sel_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen using a reduced 66x16 raster (82x22 total)
// so whole frames fit in a short run; pix_en is high every second clock.
module tb_vga_pattern_gen;
  localparam int HA = 66, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 82
  localparam int VT = VA + VF + VS + VB;   // 22

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] fg_rgb = 3'b000;
  logic [3:0] sel_pos = 4'd0;
  logic       hsync, vsync, de, frame_start;
  logic [9:0] x, y;
  logic [2:0] rgb;

  int n_checks = 0;
  int n_fail = 0;
  int pos_h = 0, pos_v = 0;
  logic fs_seen = 1'b0;
  int fs_total = 0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(1), .CELL_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .fg_rgb(fg_rgb),
    .sel_pos(sel_pos), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // One pixel tick: pix_en high for one clock, then low for one clock.
  task automatic tick();
    @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    fs_seen = frame_start;
    if (frame_start) fs_total++;
    if (pos_h == HT - 1) begin
      pos_h = 0;
      pos_v = (pos_v == VT - 1) ? 0 : pos_v + 1;
    end else begin
      pos_h = pos_h + 1;
    end
  endtask

  // Tick until the outputs show pixel (h,v).
  task automatic goto_pixel(input int h, input int v);
    int guard;
    guard = 0;
    while (!(pos_h == h && pos_v == v) && guard < HT * VT + 2) begin
      tick();
      guard++;
    end
    check("goto_bound", 32'(guard < HT * VT + 2), 32'd1);
    tick();
  endtask

  initial begin
    int hs_low, vs_low, de_hi, rgb_nz;
    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_de", 32'(de), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;

    // Frame A: default settings; a mid-frame switch to bars must not show.
    hs_low = 0; vs_low = 0; de_hi = 0; rgb_nz = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i == 8 * HT) begin
        mode = 2'd1;
        fg_rgb = 3'b111;
      end
      tick();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_hi++;
      if (rgb != 3'b000) rgb_nz++;
    end
    check("hsync_low_cnt", 32'(hs_low), 32'd176);
    check("vsync_low_cnt", 32'(vs_low), 32'd164);
    check("de_high_cnt", 32'(de_hi), 32'd1056);
    check("frameA_rgb_nz", 32'(rgb_nz), 32'd0);
    check("frameA_fs_cnt", 32'(fs_total), 32'd1);

    // Frame B: colour bars, BAR_W = 8, last bar absorbs x=64,65.
    goto_pixel(0, 0);
    check("B_fs", 32'(fs_seen), 32'd1);
    check("B_rgb_x0", 32'(rgb), 32'b000);
    check("B_de_x0", 32'(de), 32'd1);
    goto_pixel(8, 0);
    check("B_rgb_x8", 32'(rgb), 32'b001);
    check("B_x_x8", 32'(x), 32'd8);
    goto_pixel(16, 0);
    check("B_rgb_x16", 32'(rgb), 32'b010);
    goto_pixel(63, 0);
    check("B_rgb_x63", 32'(rgb), 32'b111);
    goto_pixel(65, 0);
    check("B_rgb_x65", 32'(rgb), 32'b111);
    goto_pixel(66, 0);
    check("B_rgb_x66", 32'(rgb), 32'b000);
    check("B_de_x66", 32'(de), 32'd0);
    goto_pixel(69, 0);
    check("B_hsync_69", 32'(hsync), 32'd1);
    goto_pixel(70, 0);
    check("B_hsync_70", 32'(hsync), 32'd0);
    goto_pixel(0, 17);
    check("B_vsync_v17", 32'(vsync), 32'd1);
    goto_pixel(0, 18);
    check("B_vsync_v18", 32'(vsync), 32'd0);
    check("B_y_v18", 32'(y), 32'd18);

    // Frame C: checkerboard with 4-pixel cells.
    mode = 2'd2; fg_rgb = 3'b111;
    goto_pixel(0, 0);
    check("C_rgb_0_0", 32'(rgb), 32'b000);
    goto_pixel(4, 0);
    check("C_rgb_4_0", 32'(rgb), 32'b111);
    goto_pixel(0, 4);
    check("C_rgb_0_4", 32'(rgb), 32'b111);
    goto_pixel(4, 4);
    check("C_rgb_4_4", 32'(rgb), 32'b000);

    // Frame D: band 2 (x 16..23) highlighted.
    mode = 2'd3; sel_pos = 4'b0010; fg_rgb = 3'b100;
    goto_pixel(15, 0);
    check("D_rgb_x15", 32'(rgb), 32'b000);
    goto_pixel(16, 0);
    check("D_rgb_x16", 32'(rgb), 32'b100);
    goto_pixel(23, 0);
    check("D_rgb_x23", 32'(rgb), 32'b100);
    goto_pixel(24, 0);
    check("D_rgb_x24", 32'(rgb), 32'b000);

    // Frame E: inverted band.
    sel_pos = 4'b1010;
    goto_pixel(15, 0);
    check("E_rgb_x15", 32'(rgb), 32'b100);
    goto_pixel(16, 0);
    check("E_rgb_x16", 32'(rgb), 32'b000);
    goto_pixel(65, 0);
    check("E_rgb_x65", 32'(rgb), 32'b100);
    goto_pixel(30, 10);
    check("E_de_30_10", 32'(de), 32'd1);
    check("E_rgb_30_10", 32'(rgb), 32'b100);

    // Asynchronous reset mid-frame.
    #1 rst_n = 1'b0;
    #1;
    check("ar_hsync", 32'(hsync), 32'd1);
    check("ar_vsync", 32'(vsync), 32'd1);
    check("ar_de", 32'(de), 32'd0);
    check("ar_rgb", 32'(rgb), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pos_h = 0; pos_v = 0;
    tick();
    check("rel_fs", 32'(fs_seen), 32'd1);
    check("rel_de", 32'(de), 32'd1);
    check("rel_x", 32'(x), 32'd0);
    check("rel_y", 32'(y), 32'd0);
    check("rel_rgb", 32'(rgb), 32'b100);

    // pix_en held low: everything frozen.
    repeat (20) @(negedge clk);
    check("frz_de", 32'(de), 32'd1);
    check("frz_x", 32'(x), 32'd0);
    check("frz_rgb", 32'(rgb), 32'b100);
    check("frz_hsync", 32'(hsync), 32'd1);
    check("frz_fs", 32'(frame_start), 32'd0);
    tick();
    check("post_frz_x", 32'(x), 32'd1);
    check("post_frz_fs", 32'(fs_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
